// File: rtl/ledtest_led_pkg.sv
// Shared definitions for the ledtest LED breather: FSM state encoding.
package ledtest_led_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2,
    FADE_OUT  = 2'd3
  } led_state_e;

endpackage

// File: rtl/ledtest_led_pwm.sv
// Free-running PWM counter and comparator with a registered LED output.
module ledtest_led_pwm #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PWM_W-1:0] duty,
  output logic             led
);

  logic [PWM_W-1:0] cnt_q;
  logic [PWM_W-1:0] cnt_d;
  logic             led_q;
  logic             led_d;

  assign cnt_d = cnt_q + 1'b1;
  assign led_d = (cnt_q < duty);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      led_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/ledtest_led_breather.sv
// Turns the PIO enable level into a breathing LED: triangular duty ramp while
// enabled, fade-out to idle when disabled.
module ledtest_led_breather
  import ledtest_led_pkg::*;
#(
  parameter int TICK_DIV   = 50000,
  parameter int STEP_TICKS = 4,
  parameter int PWM_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             led,
  output logic             busy,
  output logic [PWM_W-1:0] duty_level
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0]    STEP_LAST  = SW'(STEP_TICKS - 1);
  localparam logic [PWM_W-1:0] DUTY_MAX   = '1;

  logic [PW-1:0]    presc_q;
  logic [PW-1:0]    presc_d;
  logic [SW-1:0]    stepc_q;
  logic [SW-1:0]    stepc_d;
  logic             tick;
  logic             step;
  led_state_e       state_q;
  logic [PWM_W-1:0] duty_q;
  logic             busy_q;

  assign tick = (presc_q == PRESC_LAST);
  assign step = tick && (stepc_q == STEP_LAST);

  // Both counters free-run independently of the FSM, so the first step after
  // enable can arrive early.
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    stepc_d = stepc_q;
    if (tick) begin
      stepc_d = (stepc_q == STEP_LAST) ? '0 : stepc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      stepc_q <= '0;
    end else begin
      presc_q <= presc_d;
      stepc_q <= stepc_d;
    end
  end

  // Enable changes win over a coincident step; that step is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      duty_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          duty_q <= '0;
          if (enable) begin
            state_q <= RAMP_UP;
            busy_q  <= 1'b1;
          end
        end
        RAMP_UP: begin
          if (!enable) begin
            state_q <= FADE_OUT;
          end else if (step) begin
            if (duty_q == DUTY_MAX) state_q <= RAMP_DOWN;
            else                    duty_q  <= duty_q + 1'b1;
          end
        end
        RAMP_DOWN: begin
          if (!enable) begin
            state_q <= FADE_OUT;
          end else if (step) begin
            if (duty_q == '0) state_q <= RAMP_UP;
            else              duty_q  <= duty_q - 1'b1;
          end
        end
        FADE_OUT: begin
          if (enable) begin
            state_q <= RAMP_UP;
          end else if (duty_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (step) begin
            duty_q <= duty_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          duty_q  <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  ledtest_led_pwm #(
    .PWM_W (PWM_W)
  ) u_pwm (
    .clk   (clk),
    .reset (reset),
    .duty  (duty_q),
    .led   (led)
  );

  assign busy       = busy_q;
  assign duty_level = duty_q;

endmodule

// File: tb/tb_ledtest_led_breather.sv
// Self-checking bench for ledtest_led_breather (TICK_DIV=4, STEP_TICKS=2, PWM_W=3).
module tb_ledtest_led_breather;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       led;
  logic       busy;
  logic [2:0] duty_level;

  int n_cmp;
  int n_err;

  // Reference model: edge index since reset release, duty, activity and direction
  // (+1 up, -1 down, 0 fading).
  int unsigned e;
  int          m_duty;
  bit          m_active;
  int          m_dir;

  typedef struct {
    int unsigned at_edge;
    int          duty;
    int          busy;
  } vec_t;

  vec_t tbl [9];
  int   win [17];

  ledtest_led_breather #(
    .TICK_DIV   (4),
    .STEP_TICKS (2),
    .PWM_W      (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .led        (led),
    .busy       (busy),
    .duty_level (duty_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock with the given enable: advance model, compare all outputs.
  task automatic cyc(input logic en);
    bit step;
    int led_e;
    int nd;
    enable = en;
    @(posedge clk);
    step  = ((e % 8) == 7);
    led_e = (int'(e % 8) < m_duty) ? 1 : 0;
    if (!m_active) begin
      if (en) begin
        m_active = 1'b1;
        m_dir    = 1;
      end
    end else if (m_dir == 0) begin
      if (en)               m_dir = 1;
      else if (m_duty == 0) m_active = 1'b0;
      else if (step)        m_duty = m_duty - 1;
    end else begin
      if (!en) begin
        m_dir = 0;
      end else if (step) begin
        nd = m_duty + m_dir;
        if (nd > 7 || nd < 0) m_dir = -m_dir;
        else                  m_duty = nd;
      end
    end
    e++;
    #1;
    chk("model_duty", int'(duty_level), m_duty);
    chk("model_busy", int'(busy), m_active ? 1 : 0);
    chk("model_led", int'(led), led_e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    enable = 1'b1;
    reset  = 1'b1;
    #1;
    chk("rst_led", int'(led), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_duty", int'(duty_level), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_hold_busy", int'(busy), 0);
    chk("rst_hold_duty", int'(duty_level), 0);
    chk("rst_hold_led", int'(led), 0);
    @(negedge clk);
    reset    = 1'b0;
    e        = 0;
    m_duty   = 0;
    m_active = 1'b0;
    m_dir    = 0;
  endtask

  initial begin
    int idx;
    int len;
    logic en;
    n_cmp  = 0;
    n_err  = 0;
    reset  = 1'b0;
    enable = 1'b0;
    tbl[0] = '{0,   0, 1};
    tbl[1] = '{6,   0, 1};
    tbl[2] = '{7,   1, 1};
    tbl[3] = '{55,  7, 1};
    tbl[4] = '{63,  7, 1};
    tbl[5] = '{71,  6, 1};
    tbl[6] = '{119, 0, 1};
    tbl[7] = '{127, 0, 1};
    tbl[8] = '{135, 1, 1};
    foreach (win[i]) win[i] = 0;
    #2;

    // Reset, then steady enable: triangle ramp with held turning points.
    do_reset();
    idx = 0;
    for (int unsigned k = 0; k < 136; k++) begin
      cyc(1'b1);
      win[k / 8] += int'(led);
      if (idx < 9 && tbl[idx].at_edge == k) begin
        chk($sformatf("ramp_duty_e%0d", k), int'(duty_level), tbl[idx].duty);
        chk($sformatf("ramp_busy_e%0d", k), int'(busy), tbl[idx].busy);
        idx++;
      end
    end
    chk("pwm_duty0_highs", win[0], 0);
    chk("pwm_duty3_highs", win[3], 3);
    chk("pwm_duty7_highs", win[7], 7);

    // Fade from duty 5 down to idle.
    do_reset();
    for (int unsigned k = 0; k < 40; k++) cyc(1'b1);
    chk("fade_start_duty", int'(duty_level), 5);
    for (int unsigned k = 40; k < 80; k++) begin
      cyc(1'b0);
      if (k % 8 == 7) chk($sformatf("fade_duty_e%0d", k), int'(duty_level), 5 - int'((k - 39) / 8));
    end
    chk("fade_busy_at_zero", int'(busy), 1);
    cyc(1'b0);
    chk("fade_idle_busy", int'(busy), 0);
    for (int k = 0; k < 10; k++) cyc(1'b0);
    chk("fade_idle_led", int'(led), 0);

    // Re-enable during fade at duty 2.
    do_reset();
    for (int unsigned k = 0; k < 40; k++) cyc(1'b1);
    for (int unsigned k = 40; k < 64; k++) cyc(1'b0);
    chk("reen_start_duty", int'(duty_level), 2);
    for (int unsigned k = 64; k < 80; k++) begin
      cyc(1'b1);
      if (k == 71) chk("reen_duty_3", int'(duty_level), 3);
      if (k == 79) chk("reen_duty_4", int'(duty_level), 4);
    end

    // Enable edges coincident with a step: state changes, duty held.
    do_reset();
    for (int unsigned k = 0; k < 47; k++) cyc(1'b1);
    cyc(1'b0);
    chk("coinc_fall_duty", int'(duty_level), 5);
    for (int unsigned k = 48; k < 56; k++) cyc(1'b0);
    chk("coinc_fade_duty", int'(duty_level), 4);
    for (int unsigned k = 56; k < 63; k++) cyc(1'b0);
    cyc(1'b1);
    chk("coinc_rise_duty", int'(duty_level), 4);
    for (int unsigned k = 64; k < 72; k++) cyc(1'b1);
    chk("coinc_ramp_duty", int'(duty_level), 5);

    // Asynchronous reset mid-ramp at duty 6 while led is high.
    do_reset();
    for (int unsigned k = 0; k < 49; k++) cyc(1'b1);
    chk("midrst_pre_duty", int'(duty_level), 6);
    chk("midrst_pre_led", int'(led), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_led", int'(led), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_duty", int'(duty_level), 0);
    @(negedge clk);

    // Randomized enable bursts against the model.
    do_reset();
    for (int b = 0; b < 40; b++) begin
      en  = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 60));
      for (int k = 0; k < len; k++) cyc(en);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
